// File: rtl/cpu_mux_pkg.sv
// Shared definitions for the CPU-datapath stream muxes.
//   clog2_min1 : index width for a channel count, never less than 1 bit
//   MAX_CH     : largest supported channel count
//   ch_idx_t   : channel index wide enough for MAX_CH channels
package cpu_mux_pkg;

  localparam int MAX_CH = 16;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef logic [clog2_min1(MAX_CH)-1:0] ch_idx_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Picks the first asserted request scanning cyclically upward from ptr.
// Ports:
//   req     in   NUM_CH  request vector
//   ptr     in   SEL_W   highest-priority index (must be < NUM_CH)
//   gnt     out  NUM_CH  one-hot grant, all zero when no request
//   gnt_idx out  SEL_W   index of the granted request (0 when none)
//   any_gnt out  1       at least one request present
module rr_arbiter
  import cpu_mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = clog2_min1(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [SEL_W-1:0]  gnt_idx,
  output logic              any_gnt
);

  logic [2*NUM_CH-1:0] req2;
  logic [NUM_CH-1:0]   rot;
  int                  pos;

  // Doubling the vector lets a plain shift turn the cyclic scan into a
  // linear one starting at bit 0.
  assign req2 = {req, req};
  assign rot  = NUM_CH'(req2 >> ptr);

  always_comb begin
    any_gnt = |rot;
    gnt_idx = '0;
    gnt     = '0;
    pos     = 0;
    // Downward loop: the last hit written is the lowest rotated offset.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rot[i]) begin
        pos = int'(ptr) + i;
        if (pos >= NUM_CH) pos = pos - NUM_CH;
        gnt_idx = SEL_W'(pos);
      end
    end
    for (int j = 0; j < NUM_CH; j++) begin
      gnt[j] = any_gnt && (gnt_idx == SEL_W'(j));
    end
  end

endmodule

// File: rtl/rr_stream_mux.sv
// N-input valid/ready stream mux with a single-entry registered output.
// Round-robin arbitration by default; define RR_STREAM_MUX_FIXED_PRIO_EN
// for fixed priority (lowest valid index wins, no rotating pointer).
// Ports:
//   clk       in   1             clock
//   rst_n     in   1             asynchronous active-low reset
//   in_valid  in   NUM_CH        per-channel valid
//   in_data   in   NUM_CH*WIDTH  channel i at [i*WIDTH +: WIDTH]
//   in_ready  out  NUM_CH        per-channel accept, one-hot or zero
//   out_valid out  1             output register holds a beat
//   out_data  out  WIDTH         registered payload
//   out_sel   out  SEL_W         source channel of out_data
//   out_ready in   1             downstream accept
module rr_stream_mux
  import cpu_mux_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = clog2_min1(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  input  logic                    out_ready
);

  logic [SEL_W-1:0]  rr_ptr;
  logic [NUM_CH-1:0] gnt;
  logic [SEL_W-1:0]  gnt_idx;
  logic              any_gnt;
  logic              can_load;
  logic              xfer;
  logic [WIDTH-1:0]  sel_data;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_arb (
    .req     (in_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_gnt (any_gnt)
  );

  // Uses the current out_valid only, so a full-throughput slot is available
  // whenever the held beat is being consumed this cycle.
  assign can_load = !out_valid || out_ready;
  assign in_ready = gnt & {NUM_CH{can_load && rst_n}};
  assign xfer     = any_gnt && can_load;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel_data = sel_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{gnt[i]}});
    end
  end

`ifdef RR_STREAM_MUX_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (xfer) begin
      rr_ptr <= (gnt_idx == SEL_W'(NUM_CH - 1)) ? '0 : gnt_idx + SEL_W'(1);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_sel   <= gnt_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_stream_mux.sv
module tb_rr_stream_mux;

  localparam int W = 32;
  localparam int N = 4;

`ifdef RR_STREAM_MUX_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;
  logic           out_ready;

  int n_chk  = 0;
  int n_fail = 0;

  rr_stream_mux #(.WIDTH(W), .NUM_CH(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] beat(input int ch, input int seq);
    return {8'(ch), 24'(seq)};
  endfunction

  task automatic load_ch_data();
    for (int c = 0; c < N; c++) in_data[c*W +: W] = 32'h1000_0000 + 32'(c);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  // reference model state
  bit       m_valid;
  int       m_sel;
  int       m_ptr;
  logic [W-1:0] m_data;
  bit [N-1:0] vld;
  int       seq     [N];
  int       exp_seq [N];
  int       n_acc, n_con;

  initial begin
    int exp_ch;
    int g;
    bit found;
    bit can_load;
    logic [N-1:0] exp_rdy, acc;

    rst_n     = 1'b0;
    in_valid  = '1;
    in_data   = '0;
    out_ready = 1'b1;
    load_ch_data();
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_sel", 32'(out_sel), 32'h0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = '0;
    tick();

    // single channel
    in_valid = 4'b0100;
    in_data[2*W +: W] = 32'hDEAD_BEEF;
    #1;
    chk("single_in_ready", 32'(in_ready), 32'h4);
    tick();
    in_valid = '0;
    chk("single_valid", 32'(out_valid), 32'h1);
    chk("single_data", out_data, 32'hDEAD_BEEF);
    chk("single_sel", 32'(out_sel), 32'h2);
    tick();
    chk("drain_valid", 32'(out_valid), 32'h0);
    chk("drain_data_hold", out_data, 32'hDEAD_BEEF);

    // round-robin from a fresh pointer
    do_reset();
    load_ch_data();
    in_valid  = '1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_ch = FIXED ? 0 : i % N;
      chk("rr_valid", 32'(out_valid), 32'h1);
      chk("rr_sel", 32'(out_sel), 32'(exp_ch));
      chk("rr_data", out_data, 32'h1000_0000 + 32'(exp_ch));
    end

    // backpressure: held beat came from ch3 (ch0 when fixed)
    exp_ch = FIXED ? 0 : 3;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'h0);
      tick();
      chk("bp_valid", 32'(out_valid), 32'h1);
      chk("bp_sel", 32'(out_sel), 32'(exp_ch));
      chk("bp_data", out_data, 32'h1000_0000 + 32'(exp_ch));
    end
    out_ready = 1'b1;
    tick();
    chk("resume_sel0", 32'(out_sel), 32'h0);
    tick();
    chk("resume_sel1", 32'(out_sel), FIXED ? 32'h0 : 32'h1);

    // wrap: move pointer to 3 via ch2, then ch3 and ch0 both request
    in_valid = 4'b0100;
    tick();
    chk("wrap_pre_sel", 32'(out_sel), 32'h2);
    in_valid = 4'b1001;
    tick();
    chk("wrap_sel_a", 32'(out_sel), FIXED ? 32'h0 : 32'h3);
    tick();
    chk("wrap_sel_b", 32'(out_sel), 32'h0);

    // async reset with a beat held
    out_ready = 1'b0;
    tick();
    chk("arst_pre_valid", 32'(out_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'h0);
    chk("arst_data", out_data, 32'h0);
    chk("arst_sel", 32'(out_sel), 32'h0);
    chk("arst_in_ready", 32'(in_ready), 32'h0);
    in_valid  = 4'b1010;
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_sel", 32'(out_sel), 32'h1);
    chk("post_rst_valid", 32'(out_valid), 32'h1);

    // random soak against the model
    in_valid = '0;
    do_reset();
    m_valid = 0; m_sel = 0; m_ptr = 0; m_data = '0;
    vld = '0; acc = '0; n_acc = 0; n_con = 0;
    for (int c = 0; c < N; c++) begin seq[c] = 0; exp_seq[c] = 0; end

    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < N; c++) begin
        if (acc[c]) begin
          seq[c]++;
          vld[c] = 1'b0;
        end
        if (!vld[c]) vld[c] = ($urandom_range(0, 99) < 45);
        in_data[c*W +: W] = beat(c, seq[c]);
      end
      in_valid  = vld;
      out_ready = ($urandom_range(0, 99) < 65);
      #1;

      can_load = !m_valid || out_ready;
      found = 0;
      g = 0;
      for (int k = N - 1; k >= 0; k--) begin
        if (vld[(m_ptr + k) % N]) begin
          found = 1;
          g = (m_ptr + k) % N;
        end
      end
      exp_rdy = (found && can_load) ? N'(1 << g) : '0;

      chk("soak_in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("soak_onehot0", 32'($onehot0(in_ready)), 32'h1);
      chk("soak_out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
        chk("soak_out_data", out_data, m_data);
        chk("soak_out_sel", 32'(out_sel), 32'(m_sel));
      end

      if (out_valid && out_ready) begin
        exp_ch = int'(out_data[31:24]);
        if (exp_ch < N) begin
          chk("soak_seq", 32'(out_data[23:0]), 32'(exp_seq[exp_ch]));
          chk("soak_src_sel", 32'(out_sel), 32'(exp_ch));
          exp_seq[exp_ch] = int'(out_data[23:0]) + 1;
        end else begin
          chk("soak_bad_ch", 32'(exp_ch), 32'h0);
        end
        n_con++;
      end

      acc = exp_rdy & vld;
      if (acc != 0) begin
        m_valid = 1;
        m_sel   = g;
        m_data  = beat(g, seq[g]);
        m_ptr   = FIXED ? 0 : (g + 1) % N;
        n_acc++;
      end else if (out_ready) begin
        m_valid = 0;
      end
      tick();
    end
    chk("soak_conservation", 32'(n_acc), 32'(n_con + (out_valid ? 1 : 0)));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
